shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_datapath.sv | 70 +++++++
 rtl/shift_add_multiplier.sv | 84 ++++++++
 tb/tb_shift_add_multiplier.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding and the
// default operand width.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : mult_pkg

// File: rtl/mult_datapath.sv
// Operand/partial-product registers, WIDTH+1-bit adder, right shifter,
// iteration counter and the product output register of the multiplier.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW   = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               last_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [CW-1:0]      cnt_o,
  output logic [2*WIDTH-1:0] product_o
);

  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p_shift;

  // The carry out of the upper-half add becomes the new MSB after the shift,
  // so no product bit is lost even for all-ones operands.
  always_comb begin
    sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    p_shift = {sum, p_q[WIDTH-1:1]};
  end

  always_comb begin
    a_d       = a_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (load_i) begin
      a_d   = a_i;
      p_d   = {{WIDTH{1'b0}}, b_i};
      cnt_d = '0;
    end else if (step_i) begin
      p_d   = p_shift;
      cnt_d = cnt_q + 1'b1;
      if (last_i) begin
        product_d = p_shift;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign product_o = product_q;

endmodule : mult_datapath

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one shift-add step per cycle,
// sequenced by a three-state FSM; state is exported on state_dbg.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  // Handshake: a request is taken on any rising edge where start=1 and
  // busy=0; operands are captured on that edge. start is ignored while busy.
  // done is a one-cycle pulse with product already valid in that cycle.

  state_t        state_q, state_d;
  logic          load, step, last;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        step = 1'b1;
        if (cnt == LAST_ITER) begin
          last    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  mult_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step),
    .last_i    (last),
    .a_i       (multiplicand),
    .b_i       (multiplier),
    .cnt_o     (cnt),
    .product_o (product)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign state_dbg = state_q;

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (WIDTH=16): latency, busy length,
// exact products, ignored start, reset abort and back-to-back operation.
module tb_shift_add_multiplier;
  import mult_pkg::*;

  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [1:0]     state_dbg;

  int n_assert = 0;
  int n_fail   = 0;
  logic [2*W-1:0] last_product = '0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .state_dbg    (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation from a start pulse; operands are scrambled right after
  // acceptance to show they were captured.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string tag);
    int lat;
    int busy_cnt;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (lat == 8) check({tag, "_hold_mid"}, 64'(product), 64'(last_product));
    end
    check({tag, "_latency"}, 64'(lat), 64'd16);
    check({tag, "_product"}, 64'(product), 64'(exp));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd17);
    check({tag, "_product_hold"}, 64'(product), 64'(exp));
    last_product = exp;
  endtask

  initial begin
    int k;
    int done_cnt;
    int done_at[$];
    logic [2*W-1:0] cap;

    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    start = 1'b1;
    @(negedge clk);
    check("reset_prio_start", 64'(busy), 64'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("idle_no_start", 64'(busy), 64'd0);

    run_op(16'd3, 16'd5, 32'h0000_000F, "a3_b5");
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "max_max");
    run_op(16'h0000, 16'h1234, 32'h0000_0000, "zero_a");
    run_op(16'h1234, 16'h0000, 32'h0000_0000, "zero_b");
    run_op(16'hFFFF, 16'h0002, 32'h0001_FFFE, "max_two");
    run_op(16'h00FF, 16'h0100, 32'h0000_FF00, "ff_x100");

    // Second request arrives mid-operation and must be dropped.
    @(negedge clk);
    multiplicand = 16'd7; multiplier = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; cap = '0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        multiplicand = 16'd2; multiplier = 16'd2; start = 1'b1;
      end
      if (i == 6) start = 1'b0;
      if (done) begin
        done_cnt++;
        cap = product;
      end
      @(negedge clk);
    end
    check("drop_done_count", 64'(done_cnt), 64'd1);
    check("drop_product", 64'(cap), 64'd63);
    last_product = 32'd63;

    // Reset aborts an in-flight operation.
    @(negedge clk);
    multiplicand = 16'd100; multiplier = 16'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", 64'(product), 64'd0);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    last_product = '0;
    run_op(16'd12, 16'd12, 32'd144, "after_rst");

    // start held high: accepted again in the first IDLE cycle after DONE.
    @(negedge clk);
    multiplicand = 16'd1; multiplier = 16'd1; start = 1'b1;
    done_cnt = 0;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_at.push_back(k);
        check("b2b_product", 64'(product), 64'd1);
      end
    end
    start = 1'b0;
    check("b2b_done_count", 64'(done_cnt), 64'd3);
    if (done_at.size() == 3) begin
      check("b2b_first", 64'(done_at[0]), 64'd17);
      check("b2b_period1", 64'(done_at[1] - done_at[0]), 64'd18);
      check("b2b_period2", 64'(done_at[2] - done_at[1]), 64'd18);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_shift_add_multiplier
